sr_drive_controller: RTL and testbench
======================================

// Module: sr_drive_controller
// PURPOSE
//   Upstream command stage for the sr_flipflop storage cell. Accepts set/reset
//   requests over a valid/ready handshake and drives S/R as exclusive,
//   width-controlled pulses. Checks Q feedback and reports done, or err on timeout.
//   Guarantees the forbidden S=R=1 input is never presented to the flop.
// PARAMETERS
//   PULSE_W   1   cycles S or R is held high per command (>=1)
//   TIMEOUT   4   VERIFY cycles allowed for q_fb to match before err (>=1)
//   CNT_W     8   width of saturating error counter
// PORTS
//   clk        in   1      rising-edge clock, the only clock
//   rst_n      in   1      asynchronous, active-low reset
//   req_valid  in   1      command valid
//   req_op     in   1      1 = set (drive S), 0 = reset (drive R)
//   req_ready  out  1      command accepted when req_valid & req_ready
//   S          out  1      set drive to flop, registered
//   R          out  1      reset drive to flop, registered
//   q_fb       in   1      flop Q, same clock domain, sampled directly
//   busy       out  1      high in DRIVE or VERIFY
//   done       out  1      one-cycle pulse: q_fb matched the commanded op
//   err        out  1      one-cycle pulse: no match within TIMEOUT
//   err_cnt    out  CNT_W  count of err pulses, saturates at all-ones
// BEHAVIOUR
//   Reset (async, immediate): state=IDLE; S=R=done=err=busy=0; err_cnt=0.
//   FSM IDLE -> DRIVE -> VERIFY -> IDLE.
//   IDLE: req_ready=1 (combinational from state). On accept at edge k:
//     latch op; state=DRIVE; S=op, R=~op from edge k.
//   DRIVE: held PULSE_W cycles. At edge k+PULSE_W: S=R=0, state=VERIFY,
//     tcnt=0. req_ready=0 and req_valid is ignored outside IDLE.
//   VERIFY: sample q_fb every edge.
//     - Match (q_fb==op) at edge e: state=IDLE, done=1 for the cycle after e.
//     - TIMEOUT samples with no match: err=1 for one cycle, err_cnt+1 (sat),
//       state=IDLE. Last sample at edge k+PULSE_W+TIMEOUT.
//   Best-case latency with sr_flipflop: accept k -> done after edge k+PULSE_W+1.
//   done and err are mutually exclusive.
//   Back-to-back: a new request may be accepted in the done/err cycle
//     (state already IDLE). Its S/R pulse starts at that edge.
//   A command equal to the current Q is still driven and verified (idempotent).
//   Invariant: S&R==0 in every cycle, including reset and reset release.
//   Reset mid-DRIVE/VERIFY: S/R drop asynchronously; command is lost;
//     no done or err is issued.
// STRUCTURE
//   sr_ctrl_pkg: state encoding localparams (ST_IDLE, ST_DRIVE, ST_VERIFY),
//     OP_SET=1'b1, OP_RESET=1'b0.
//   One sub-module: sat_counter #(CNT_W), increment-enable, async rst_n,
//     holds at all-ones. Used for err_cnt.
//   The pulse-width and timeout counters stay inline, shared as tcnt.
// TESTING (PULSE_W=1, TIMEOUT=4, CNT_W=4, 20-unit clk; S/R/Q looped to sr_flipflop)
//   1 rst_n=0 for 2 cycles -> S=R=done=err=busy=0, err_cnt=0.
//     After release: req_ready=1.
//   2 req_valid=1, op=1, accepted edge k -> S=1 only in [k,k+1), Q=1 at k+1,
//     done pulse after k+2, busy low after k+2.
//   3 op=0 issued in the same cycle as the done from scenario 2 -> accepted
//     back-to-back; R=1 for one cycle; Q=0; done after 2 more edges.
//   4 q_fb forced 0, op=1 -> no done, err pulse after edge k+5, err_cnt=1.
//     Repeat 16x -> err_cnt stays 4'hF.
//   5 req_valid held high through DRIVE/VERIFY with changing req_op ->
//     req_ready=0, no second accept; latched op unchanged.
//   6 rst_n pulsed low mid-DRIVE (S=1) -> S=0 before next edge, state IDLE,
//     no done/err. Assertion S&R==0 checked every cycle of every test.

Source files
------------

// File: rtl/sr_ctrl_pkg.sv
// Shared encodings for the S/R drive controller: FSM states and command opcodes.
// Pure declarations; no latency and no backpressure of its own.
package sr_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_VERIFY = 2'd2
    } state_t;

    localparam logic OP_SET   = 1'b1;
    localparam logic OP_RESET = 1'b0;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: count follows inc by one edge and holds at all-ones.
// No backpressure: every inc pulse is absorbed, increments beyond saturation are dropped.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/sr_drive_controller.sv
// Drives exclusive S/R pulses into the SR cell and verifies Q; done after PULSE_W+1 edges best case.
// Backpressure: req_ready is high only in IDLE, so one command is in flight at a time.
module sr_drive_controller
    import sr_ctrl_pkg::*;
#(
    parameter int PULSE_W = 1,
    parameter int TIMEOUT = 4,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    input  logic             req_op,
    output logic             req_ready,
    output logic             S,
    output logic             R,
    input  logic             q_fb,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int TCNT_W = $clog2(max2(PULSE_W, TIMEOUT) + 1);

    state_t            state, state_nxt;
    logic              op, op_nxt;
    logic [TCNT_W-1:0] tcnt, tcnt_nxt;
    logic              s_nxt, r_nxt, done_nxt, err_nxt;

    assign req_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            op    <= OP_RESET;
            tcnt  <= '0;
            S     <= 1'b0;
            R     <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            op    <= op_nxt;
            tcnt  <= tcnt_nxt;
            S     <= s_nxt;
            R     <= r_nxt;
            done  <= done_nxt;
            err   <= err_nxt;
        end
    end

    // S and R are only ever derived from a single op bit and its complement,
    // so the forbidden S=R=1 combination cannot be produced.
    always_comb begin
        state_nxt = state;
        op_nxt    = op;
        tcnt_nxt  = tcnt;
        s_nxt     = 1'b0;
        r_nxt     = 1'b0;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    op_nxt    = req_op;
                    state_nxt = ST_DRIVE;
                    tcnt_nxt  = '0;
                    s_nxt     = req_op;
                    r_nxt     = ~req_op;
                end
            end
            ST_DRIVE: begin
                if (tcnt == TCNT_W'(PULSE_W - 1)) begin
                    state_nxt = ST_VERIFY;
                    tcnt_nxt  = '0;
                end else begin
                    tcnt_nxt  = tcnt + TCNT_W'(1);
                    s_nxt     = op;
                    r_nxt     = ~op;
                end
            end
            ST_VERIFY: begin
                if (q_fb == op) begin
                    done_nxt  = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (tcnt == TCNT_W'(TIMEOUT - 1)) begin
                    err_nxt   = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    tcnt_nxt  = tcnt + TCNT_W'(1);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    sat_counter #(
        .W(CNT_W)
    ) u_err_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (err_nxt),
        .cnt  (err_cnt)
    );

endmodule

// File: tb/tb_sr_drive_controller.sv
// Directed bench: controller looped through a behavioural SR cell, with q_fb override for timeouts.
module tb_sr_drive_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic       req_op;
    logic       req_ready;
    logic       S, R;
    logic       q_fb;
    logic       busy, done, err;
    logic [3:0] err_cnt;
    logic       q = 1'b0;
    logic       force_zero;
    int         n_cmp = 0;
    int         n_err = 0;

    always #10 clk = ~clk;

    always @(posedge clk) begin
        if (S)      q <= 1'b1;
        else if (R) q <= 1'b0;
    end

    assign q_fb = force_zero ? 1'b0 : q;

    sr_drive_controller #(
        .PULSE_W(1),
        .TIMEOUT(4),
        .CNT_W  (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_op   (req_op),
        .req_ready(req_ready),
        .S        (S),
        .R        (R),
        .q_fb     (q_fb),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .err_cnt  (err_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_cmd(input logic op, output logic saw_done, output logic saw_err);
        req_valid = 1'b1;
        req_op    = op;
        tick();
        req_valid = 1'b0;
        saw_done  = 1'b0;
        saw_err   = 1'b0;
        for (int i = 0; i < 20 && !saw_done && !saw_err; i++) begin
            tick();
            saw_done = done;
            saw_err  = err;
        end
        chk("cmd_completes", {31'd0, saw_done | saw_err}, 32'd1);
    endtask

    always @(negedge clk) chk("s_and_r", {31'd0, S & R}, 32'd0);

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic d, e;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_op     = 1'b0;
        force_zero = 1'b0;

        // Reset state
        tick(); tick();
        chk("rst_S", S, 0);
        chk("rst_R", R, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err_cnt", err_cnt, 0);
        rst_n = 1'b1;
        tick();
        chk("rel_ready", req_ready, 1);

        // Set command, best-case latency
        req_valid = 1'b1; req_op = 1'b1;
        tick();
        chk("set_S_k", S, 1);
        chk("set_R_k", R, 0);
        chk("set_busy_k", busy, 1);
        chk("set_ready_k", req_ready, 0);
        req_valid = 1'b0;
        tick();
        chk("set_S_k1", S, 0);
        chk("set_done_k1", done, 0);
        chk("set_busy_k1", busy, 1);
        tick();
        chk("set_done_k2", done, 1);
        chk("set_busy_k2", busy, 0);
        chk("set_ready_k2", req_ready, 1);

        // Back-to-back reset command issued in the done cycle
        req_valid = 1'b1; req_op = 1'b0;
        tick();
        chk("b2b_R_k", R, 1);
        chk("b2b_S_k", S, 0);
        chk("b2b_done_k", done, 0);
        req_valid = 1'b0;
        tick();
        chk("b2b_R_k1", R, 0);
        chk("b2b_done_k1", done, 0);
        tick();
        chk("b2b_done_k2", done, 1);
        tick();
        chk("b2b_done_pulse", done, 0);

        // Timeout: q_fb stuck low
        force_zero = 1'b1;
        req_valid = 1'b1; req_op = 1'b1;
        tick();
        chk("to_S_k", S, 1);
        req_valid = 1'b0;
        for (int j = 1; j <= 4; j++) begin
            tick();
            chk("to_no_err", err, 0);
            chk("to_no_done", done, 0);
        end
        tick();
        chk("to_err_k5", err, 1);
        chk("to_done_k5", done, 0);
        chk("to_err_cnt1", err_cnt, 1);
        chk("to_busy_k5", busy, 0);
        tick();
        chk("to_err_pulse", err, 0);
        chk("to_err_cnt_hold", err_cnt, 1);

        // Saturation of err_cnt
        for (int i = 1; i <= 16; i++) begin
            run_cmd(1'b1, d, e);
            chk("sat_err", {31'd0, e}, 32'd1);
            if (i == 14) chk("sat_cnt_15", err_cnt, 4'hF);
        end
        chk("sat_cnt_hold", err_cnt, 4'hF);
        force_zero = 1'b0;
        tick();

        // Request held during DRIVE/VERIFY with changing op
        req_valid = 1'b1; req_op = 1'b0;
        tick();
        chk("hold_R_k", R, 1);
        chk("hold_ready_k", req_ready, 0);
        req_op = 1'b1;
        tick();
        chk("hold_ready_k1", req_ready, 0);
        chk("hold_S_k1", S, 0);
        chk("hold_R_k1", R, 0);
        tick();
        chk("hold_done_k2", done, 1);
        chk("hold_S_k2", S, 0);
        req_valid = 1'b0;
        tick();
        chk("hold_busy_after", busy, 0);
        chk("hold_S_after", S, 0);

        // Reset during DRIVE
        req_valid = 1'b1; req_op = 1'b1;
        tick();
        chk("mid_S_k", S, 1);
        req_valid = 1'b0;
        rst_n = 1'b0;
        #2;
        chk("mid_S_async", S, 0);
        chk("mid_busy", busy, 0);
        chk("mid_ready", req_ready, 1);
        chk("mid_err_cnt", err_cnt, 0);
        #3 rst_n = 1'b1;
        for (int j = 0; j < 6; j++) begin
            tick();
            chk("mid_no_done", done, 0);
            chk("mid_no_err", err, 0);
        end
        run_cmd(1'b1, d, e);
        chk("post_rst_done", {31'd0, d}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
